// File: rtl/gsplat_mem_responder.sv
// On-chip 64-bit memory window answering burst read/write requests.
// Read data returns two cycles after the read ack; writes are acked one qword per handshake.
module gsplat_mem_responder #(
    parameter logic [28:0] BASE_ADDR = 29'h06040000,
    parameter int unsigned AW        = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [28:0] rd_addr,
    input  logic [7:0]  rd_burstcnt,
    input  logic        rd_req,
    output logic        rd_ack,
    output logic [63:0] rd_data,
    output logic        rd_data_valid,
    input  logic [28:0] wr_addr,
    input  logic [7:0]  wr_burstcnt,
    input  logic [63:0] wr_data,
    input  logic [7:0]  wr_be,
    input  logic        wr_req,
    output logic        wr_ack,
    output logic        wr_busy,
    output logic        oob_err
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_GUARD = 3'd2,
        WR_BURST = 3'd3,
        WR_GUARD = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [28:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  rd_rem_q, rd_rem_d;
    logic [28:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]  wr_rem_q, wr_rem_d;
    logic        pref_wr_q, pref_wr_d;
    logic        rd_ack_q, rd_ack_d;
    logic        wr_ack_q, wr_ack_d;
    logic        wr_busy_q, wr_busy_d;

    logic        s1_vld_q, s1_oob_q;
    logic        rd_valid_q;
    logic [63:0] rd_data_q;
    logic        oob_err_q;

    logic        rd_issue_c, wr_go_c;
    logic [28:0] wr_waddr_c;
    logic [28:0] rd_off_c, wr_off_c;
    logic        rd_oob_c, wr_oob_c;
    logic [7:0]  rd_len_c, wr_len_c;

    logic [63:0] mem [DEPTH];
    logic [63:0] ram_q;

    // A zero burst count means a single qword.
    assign rd_len_c = (rd_burstcnt == 8'd0) ? 8'd1 : rd_burstcnt;
    assign wr_len_c = (wr_burstcnt == 8'd0) ? 8'd1 : wr_burstcnt;

    // Window offset wraps modulo 2^29; anything at or beyond DEPTH is outside.
    assign rd_off_c = rd_ptr_q - BASE_ADDR;
    assign wr_off_c = wr_waddr_c - BASE_ADDR;
    assign rd_oob_c = (rd_off_c >> AW) != 29'd0;
    assign wr_oob_c = (wr_off_c >> AW) != 29'd0;

    // Next-state and handshake decode.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_rem_d   = rd_rem_q;
        wr_ptr_d   = wr_ptr_q;
        wr_rem_d   = wr_rem_q;
        pref_wr_d  = pref_wr_q;
        rd_ack_d   = 1'b0;
        wr_ack_d   = 1'b0;
        wr_busy_d  = wr_busy_q;
        rd_issue_c = 1'b0;
        wr_go_c    = 1'b0;
        wr_waddr_c = wr_ptr_q;

        case (state_q)
            IDLE: begin
                if (rd_req && (!wr_req || !pref_wr_q)) begin
                    rd_ptr_d  = rd_addr;
                    rd_rem_d  = rd_len_c;
                    rd_ack_d  = 1'b1;
                    pref_wr_d = 1'b1;
                    state_d   = RD_BURST;
                end else if (wr_req) begin
                    wr_go_c    = 1'b1;
                    wr_waddr_c = wr_addr;
                    wr_ptr_d   = wr_addr + 29'd1;
                    wr_rem_d   = wr_len_c - 8'd1;
                    wr_ack_d   = 1'b1;
                    wr_busy_d  = 1'b1;
                    pref_wr_d  = 1'b0;
                    state_d    = WR_BURST;
                end
            end
            RD_BURST: begin
                rd_issue_c = 1'b1;
                rd_ptr_d   = rd_ptr_q + 29'd1;
                rd_rem_d   = rd_rem_q - 8'd1;
                if (rd_rem_q == 8'd1) begin
                    state_d = RD_GUARD;
                end
            end
            RD_GUARD: begin
                state_d = IDLE;
            end
            WR_BURST: begin
                if (wr_rem_q == 8'd0) begin
                    state_d = WR_GUARD;
                end else if (wr_req && !wr_ack_q) begin
                    wr_go_c  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 29'd1;
                    wr_rem_d = wr_rem_q - 8'd1;
                    wr_ack_d = 1'b1;
                end
            end
            WR_GUARD: begin
                state_d   = IDLE;
                wr_busy_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            rd_rem_q   <= '0;
            wr_ptr_q   <= '0;
            wr_rem_q   <= '0;
            pref_wr_q  <= 1'b0;
            rd_ack_q   <= 1'b0;
            wr_ack_q   <= 1'b0;
            wr_busy_q  <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_oob_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            oob_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_rem_q   <= rd_rem_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_rem_q   <= wr_rem_d;
            pref_wr_q  <= pref_wr_d;
            rd_ack_q   <= rd_ack_d;
            wr_ack_q   <= wr_ack_d;
            wr_busy_q  <= wr_busy_d;
            s1_vld_q   <= rd_issue_c;
            s1_oob_q   <= rd_oob_c;
            rd_valid_q <= s1_vld_q;
            if (s1_vld_q) begin
                rd_data_q <= s1_oob_q ? 64'h0 : ram_q;
            end
            oob_err_q  <= oob_err_q | (s1_vld_q & s1_oob_q) | (wr_go_c & wr_oob_c);
        end
    end

    // Storage: registered read port, byte-masked write port, no reset.
    always_ff @(posedge clk) begin
        if (rd_issue_c) begin
            ram_q <= mem[rd_off_c[AW-1:0]];
        end
        if (wr_go_c && !wr_oob_c) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_be[b]) begin
                    mem[wr_off_c[AW-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_ack        = rd_ack_q;
    assign rd_data       = rd_data_q;
    assign rd_data_valid = rd_valid_q;
    assign wr_ack        = wr_ack_q;
    assign wr_busy       = wr_busy_q;
    assign oob_err       = oob_err_q;

endmodule

// File: tb/tb_gsplat_mem_responder.sv
// Directed bench for gsplat_mem_responder with a read-data scoreboard and reference memory.
module tb_gsplat_mem_responder;

    localparam logic [28:0] BASE = 29'h06040000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [28:0] rd_addr = '0;
    logic [7:0]  rd_burstcnt = '0;
    logic        rd_req = 1'b0;
    logic        rd_ack;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic [28:0] wr_addr = '0;
    logic [7:0]  wr_burstcnt = '0;
    logic [63:0] wr_data = '0;
    logic [7:0]  wr_be = '0;
    logic        wr_req = 1'b0;
    logic        wr_ack;
    logic        wr_busy;
    logic        oob_err;

    gsplat_mem_responder #(
        .BASE_ADDR(BASE),
        .AW(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rd_addr(rd_addr),
        .rd_burstcnt(rd_burstcnt),
        .rd_req(rd_req),
        .rd_ack(rd_ack),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .wr_addr(wr_addr),
        .wr_burstcnt(wr_burstcnt),
        .wr_data(wr_data),
        .wr_be(wr_be),
        .wr_req(wr_req),
        .wr_ack(wr_ack),
        .wr_busy(wr_busy),
        .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] mem_m [1024];
    logic [63:0] last_data = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_rd(input logic [28:0] a);
        logic [28:0] off;
        off = a - BASE;
        if (off < 29'd1024) return mem_m[off[9:0]];
        return 64'h0;
    endfunction

    function automatic void model_wr(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
        logic [28:0] off;
        off = a - BASE;
        if (off < 29'd1024) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem_m[off[9:0]][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    // Scoreboard: every valid must match the next expected qword and its cycle; idle cycles hold data.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rd_data_valid) begin
                chk("valid_has_exp", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    chk("rd_data", rd_data, mon_e.data);
                    chk("rd_latency", 64'(cyc), 64'(mon_e.cyc));
                    last_data = mon_e.data;
                end
            end else begin
                chk("rd_hold", rd_data, last_data);
            end
        end
    end

    function automatic void push_exp(input logic [28:0] a, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = model_rd(a + 29'(i));
            e.cyc  = cyc + 2 + i;
            exp_q.push_back(e);
        end
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        exp_q.delete();
        last_data = '0;
        #1;
        chk("rst_rd_ack", 64'(rd_ack), 64'd0);
        chk("rst_rd_valid", 64'(rd_data_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_wr_ack", 64'(wr_ack), 64'd0);
        chk("rst_wr_busy", 64'(wr_busy), 64'd0);
        chk("rst_oob_err", 64'(oob_err), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_wr_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 10 && !done; i++) begin
            if (!wr_busy) done = 1'b1;
            else @(negedge clk);
        end
        chk("wr_busy_off", 64'(done), 64'd1);
    endtask

    task automatic rd_start(input logic [28:0] a, input logic [7:0] cnt, input bit hold);
        bit got;
        int n;
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        rd_addr     = a;
        rd_burstcnt = cnt;
        rd_req      = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rd_ack;
        end
        chk("rd_ack_seen", 64'(got), 64'd1);
        if (got) push_exp(a, n);
        if (!hold) rd_req = 1'b0;
        @(negedge clk);
        chk("rd_ack_pulse", 64'(rd_ack), 64'd0);
        rd_req = 1'b0;
    endtask

    task automatic drain();
        int acks;
        acks = 0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            if (rd_ack) acks++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (4) begin
            @(negedge clk);
            if (rd_ack) acks++;
        end
        chk("no_reaccept", 64'(acks), 64'd0);
    endtask

    task automatic wr_burst(input logic [28:0] a, input logic [7:0] cnt, input logic [7:0] be,
                            input logic [63:0] d0);
        bit got;
        int n;
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        wr_addr     = a;
        wr_burstcnt = cnt;
        wr_be       = be;
        wr_req      = 1'b1;
        for (int k = 0; k < n; k++) begin
            wr_data = d0 + 64'(k);
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                got = wr_ack;
            end
            chk("wr_ack_seen", 64'(got), 64'd1);
            chk("wr_busy_on", 64'(wr_busy), 64'd1);
            if (got) model_wr(a + 29'(k), wr_data, be);
        end
        wr_req = 1'b0;
        @(negedge clk);
        chk("wr_ack_pulse", 64'(wr_ack), 64'd0);
        wait_wr_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        int nv;
        for (int i = 0; i < 1024; i++) mem_m[i] = '0;
        #3;
        do_reset();

        // Tie from reset: read wins, pending write follows.
        rd_addr = BASE + 29'd2048; rd_burstcnt = 8'd1;
        wr_addr = BASE + 29'd10;   wr_burstcnt = 8'd1;
        wr_data = 64'hA5A5_5A5A_0123_4567; wr_be = 8'hFF;
        rd_req = 1'b1; wr_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rd_ack | wr_ack;
        end
        chk("tie1_order", 64'({rd_ack, wr_ack}), 64'd2);
        push_exp(BASE + 29'd2048, 1);
        rd_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = wr_ack;
        end
        chk("tie1_wr_next", 64'(got), 64'd1);
        model_wr(BASE + 29'd10, wr_data, 8'hFF);
        wr_req = 1'b0;
        drain();
        wait_wr_idle();
        chk("tie1_oob_sticky", 64'(oob_err), 64'd1);

        // Read-only transaction, then a tie must go to the write.
        rd_start(BASE + 29'd10, 8'd1, 1'b0);
        drain();
        rd_addr = BASE + 29'd10; rd_burstcnt = 8'd1;
        wr_addr = BASE + 29'd11; wr_burstcnt = 8'd1;
        wr_data = 64'h1111_2222_3333_4444; wr_be = 8'hFF;
        rd_req = 1'b1; wr_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rd_ack | wr_ack;
        end
        chk("tie2_order", 64'({rd_ack, wr_ack}), 64'd1);
        model_wr(BASE + 29'd11, wr_data, 8'hFF);
        wr_req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rd_ack;
        end
        chk("tie2_rd_next", 64'(got), 64'd1);
        push_exp(BASE + 29'd10, 1);
        rd_req = 1'b0;
        drain();

        do_reset();

        // Single write then single read.
        wr_burst(BASE, 8'd1, 8'hFF, 64'h0000_0001_0000_0000);
        rd_start(BASE, 8'd1, 1'b0);
        drain();

        // Burst of four, request held one cycle past ack.
        wr_burst(BASE, 8'd4, 8'hFF, 64'd1);
        rd_start(BASE, 8'd4, 1'b1);
        drain();

        // Partial byte enables keep the upper half.
        wr_burst(BASE + 29'd5, 8'd1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wr_burst(BASE + 29'd5, 8'd1, 8'h0F, 64'h0);
        chk("be_model", model_rd(BASE + 29'd5), 64'hFFFF_FFFF_0000_0000);
        rd_start(BASE + 29'd5, 8'd1, 1'b0);
        drain();

        // Burst running off the window end.
        wr_burst(BASE + 29'd1022, 8'd2, 8'hFF, 64'hC0DE_0000_0000_0000);
        chk("oob_before", 64'(oob_err), 64'd0);
        rd_start(BASE + 29'd1022, 8'd4, 1'b0);
        nv = 0;
        for (int i = 0; i < 20 && nv < 3; i++) begin
            @(negedge clk);
            if (rd_data_valid) nv++;
        end
        chk("oob_third_valid", 64'(oob_err), 64'd1);
        drain();

        // Write starting below the window: first qword dropped, second lands at index 0.
        wr_burst(BASE - 29'd1, 8'd2, 8'hFF, 64'h77);
        rd_start(BASE, 8'd0, 1'b0);
        drain();
        wr_burst(BASE + 29'd20, 8'd0, 8'hFF, 64'h55AA);
        rd_start(BASE + 29'd20, 8'd1, 1'b0);
        drain();

        // Reset in the middle of an eight-qword read.
        wr_burst(BASE, 8'd8, 8'hFF, 64'h100);
        rd_start(BASE, 8'd8, 1'b0);
        nv = 0;
        for (int i = 0; i < 20 && nv < 3; i++) begin
            @(negedge clk);
            if (rd_data_valid) nv++;
        end
        chk("mid_valids", 64'(nv), 64'd3);
        do_reset();
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (rd_data_valid) nv++;
        end
        chk("post_reset_quiet", 64'(nv), 64'd0);
        wr_burst(BASE + 29'd2, 8'd2, 8'hFF, 64'hBEEF_0000);
        rd_start(BASE + 29'd2, 8'd2, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gsplat_mem_responder.md
GSPLAT_MEM_RESPONDER -- requirements
Module: gsplat_mem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 29'h06040000, qword address of first word in the window.
REQ-002 SHALL have parameter AW, default 10, log2 of window depth in qwords (1024 x 64-bit).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rd_addr  input  29  qword read start address.
REQ-006 SHALL have port rd_burstcnt  input  8  read length in qwords.
REQ-007 SHALL have port rd_req  input  1  read request, held until rd_ack seen.
REQ-008 SHALL have port rd_ack  output  1  one-cycle pulse, read accepted.
REQ-009 SHALL have port rd_data  output  64  read data.
REQ-010 SHALL have port rd_data_valid  output  1  rd_data qualifier, one per qword.
REQ-011 SHALL have port wr_addr  input  29  qword write start address.
REQ-012 SHALL have port wr_burstcnt  input  8  write length in qwords.
REQ-013 SHALL have port wr_data  input  64  current write qword.
REQ-014 SHALL have port wr_be  input  8  byte enables for wr_data.
REQ-015 SHALL have port wr_req  input  1  write request, held until wr_ack seen.
REQ-016 SHALL have port wr_ack  output  1  one-cycle pulse, one qword accepted.
REQ-017 SHALL have port wr_busy  output  1  write burst in progress.
REQ-018 SHALL have port oob_err  output  1  sticky flag, access outside window.

Function
REQ-019 SHALL store 2^AW qwords in synchronous on-chip RAM; index = addr - BASE_ADDR (modulo 2^29).
REQ-020 SHALL implement FSM states IDLE, RD_BURST, RD_GUARD, WR_BURST, WR_GUARD.
REQ-021 IDLE: with rd_req=1, SHALL register rd_addr/rd_burstcnt, pulse rd_ack next cycle, enter RD_BURST.
REQ-022 rd_burstcnt=0 SHALL be treated as 1; likewise wr_burstcnt=0.
REQ-023 RD_BURST: first rd_data_valid SHALL occur 2 cycles after the rd_ack cycle, then one qword per cycle, consecutive addresses, no gaps.
REQ-024 Total rd_data_valid pulses per accepted read SHALL equal burst length exactly.
REQ-025 After last read qword SHALL spend one cycle in RD_GUARD ignoring rd_req, then IDLE.
REQ-026 rd_req SHALL be ignored from acceptance through RD_GUARD (requestor drops req one cycle after ack).
REQ-027 IDLE: with wr_req=1, SHALL write wr_data under wr_be to RAM, pulse wr_ack same registered cycle, enter WR_BURST, assert wr_busy.
REQ-028 WR_BURST: each later cycle with wr_req=1 and wr_ack=0 previous cycle SHALL write next qword at address+1 and pulse wr_ack; at most one ack every 2 cycles.
REQ-029 After burst-length acks SHALL enter WR_GUARD one cycle, deassert wr_busy on exit to IDLE.
REQ-030 Bytes with wr_be bit=0 SHALL keep prior RAM contents.
REQ-031 rd_req and wr_req both high in IDLE SHALL be arbitrated alternately: the type not served last wins; after reset read wins.
REQ-032 Read qwords outside window SHALL return 64'h0 with rd_data_valid still asserted; write qwords outside window SHALL be dropped but still acked.
REQ-033 Any out-of-window qword SHALL set oob_err=1 until reset.
REQ-034 A burst crossing window end SHALL serve in-window qwords normally and treat the remainder per REQ-032.
REQ-035 rd_data SHALL hold its last value when rd_data_valid=0.

Reset
REQ-036 reset_n=0 SHALL immediately force state IDLE, rd_ack=0, rd_data_valid=0, rd_data=0, wr_ack=0, wr_busy=0, oob_err=0, arbitration to read-first; RAM contents unspecified; an in-flight burst SHALL be abandoned with no further valid/ack pulses.

Verification
REQ-037 Write 1 qword 64'h0000_0001_0000_0000 to BASE_ADDR be=FF, then read burst 1 -> one wr_ack, one rd_data_valid 2 cycles after rd_ack with identical data.
REQ-038 Preload idx 0..3 with 1..4, read BASE_ADDR burst 4 -> 4 consecutive valids carrying 1,2,3,4; req held one cycle after ack produces no second acceptance.
REQ-039 Write 64'hFFFF..FF then 64'h0 with be=8'h0F to idx 5, read -> 64'hFFFF_FFFF_0000_0000.
REQ-040 Read BASE_ADDR+1022 burst 4 -> data idx1022, idx1023, 0, 0; oob_err=1 after third valid.
REQ-041 rd_req and wr_req raised together twice from reset -> read served first, then write; then write-first on next tie.
REQ-042 Assert reset_n=0 during 8-qword read after 3 valids -> no further valids; all outputs zero; fresh read after release completes normally.
